// File: rtl/downcounter_pwm_if.sv
// downcounter_pwm_if: bus between a waveform generator and its timing core.
//   master (parent):  drives enable, duty_cycle; receives zero, pwm_out
//   slave  (core):    receives enable, duty_cycle; drives zero, pwm_out
interface downcounter_pwm_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] duty_cycle;
    logic             zero;
    logic             pwm_out;
    modport master (output enable, duty_cycle, input zero, pwm_out);
    modport slave  (input enable, duty_cycle, output zero, pwm_out);
endinterface

// File: rtl/downcounter_pwm.sv
// downcounter_pwm: programmable tick downcounter plus WIDTH-bit PWM modulator.
//   clk    : system clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   bus    : downcounter_pwm_if.slave (enable, duty_cycle in; zero, pwm_out out)
//   DOWNCOUNTER_PWM_SHADOW_EN: when defined, duty is latched into a shadow
//   register at each PWM period boundary (and while disabled).
module downcounter_pwm #(
    parameter int PERIOD = 100,
    parameter int WIDTH  = 8
) (
    input logic               clk,
    input logic               reset,
    downcounter_pwm_if.slave  bus
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    if (PERIOD < 1) begin : g_bad_period
        $error("downcounter_pwm: PERIOD must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("downcounter_pwm: WIDTH must be >= 1");
    end

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic             pwm_q, pwm_d;
    logic [WIDTH-1:0] duty_eff;

    // Disabling reloads the tick counter so a restart is phase-aligned.
    always_comb begin
        cnt_d  = (!bus.enable || cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
        pcnt_d = bus.enable ? pcnt_q + WIDTH'(1) : '0;
        pwm_d  = bus.enable && (pcnt_q < duty_eff);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= RELOAD;
            pcnt_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            pwm_q  <= pwm_d;
        end
    end

`ifdef DOWNCOUNTER_PWM_SHADOW_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    // Load at the last count of a PWM period so the new duty starts cleanly.
    always_comb shadow_d = (!bus.enable || pcnt_q == '1) ? bus.duty_cycle : shadow_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end
    assign duty_eff = shadow_q;
`else
    assign duty_eff = bus.duty_cycle;
`endif

    // Gated by reset so PERIOD=1 (cnt held at 0) never ticks during reset.
    assign bus.zero    = bus.enable && !reset && cnt_q == '0;
    assign bus.pwm_out = pwm_q;
endmodule

// File: tb/tb_downcounter_pwm.sv
// tb_downcounter_pwm: randomized bench for downcounter_pwm against a run-index model.
module tb_downcounter_pwm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] duty = '0;
    always #5 clk = ~clk;

    downcounter_pwm_if #(.WIDTH(8)) b4 ();
    downcounter_pwm_if #(.WIDTH(8)) b1 ();
    downcounter_pwm_if #(.WIDTH(8)) b8 ();
    downcounter_pwm_if #(.WIDTH(8)) b9 ();
    assign b4.enable = en;
    assign b4.duty_cycle = duty;
    assign b1.enable = en;
    assign b1.duty_cycle = duty;
    assign b8.enable = en;
    assign b8.duty_cycle = duty;
    assign b9.enable = en;
    assign b9.duty_cycle = duty;

    downcounter_pwm #(.PERIOD(4), .WIDTH(8)) u4 (.clk(clk), .reset(reset), .bus(b4));
    downcounter_pwm #(.PERIOD(1), .WIDTH(8)) u1 (.clk(clk), .reset(reset), .bus(b1));
    downcounter_pwm #(.PERIOD(8), .WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8));
    downcounter_pwm #(.PERIOD(9), .WIDTH(8)) u9 (.clk(clk), .reset(reset), .bus(b9));

    int checks = 0;
    int failures = 0;
    // k: enabled edges since the last restart (reset or a disabled edge)
    int k = 0;
    logic [7:0] deff = '0;
    logic pwm_exp = 1'b0;
    int hc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit zexp(input int p);
        return en && !reset && (k % p == p - 1);
    endfunction

    task automatic check_all();
        check("zero_p4", b4.zero, zexp(4));
        check("zero_p1", b1.zero, zexp(1));
        check("zero_p8", b8.zero, zexp(8));
        check("zero_p9", b9.zero, zexp(9));
        check("pwm_p4", b4.pwm_out, pwm_exp);
        check("pwm_p1", b1.pwm_out, pwm_exp);
        check("pwm_p8", b8.pwm_out, pwm_exp);
        check("pwm_p9", b9.pwm_out, pwm_exp);
    endtask

    task automatic model_reset();
        k = 0;
        pwm_exp = 1'b0;
        deff = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) begin
`ifndef DOWNCOUNTER_PWM_SHADOW_EN
            deff = duty;
`endif
            if (en) begin
                pwm_exp = (k % 256) < deff;
`ifdef DOWNCOUNTER_PWM_SHADOW_EN
                if (k % 256 == 255) deff = duty;
`endif
                k++;
            end else begin
                pwm_exp = 1'b0;
                k = 0;
`ifdef DOWNCOUNTER_PWM_SHADOW_EN
                deff = duty;
`endif
            end
        end
        #1 check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic high_count(input logic [7:0] d);
        en = 1'b0;
        duty = d;
        steps(2);
        en = 1'b1;
        hc = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            hc += int'(b4.pwm_out);
        end
        check("high_count", hc, int'(d));
    endtask

    initial begin
        #2 check_all();
        steps(3);
        reset = 1'b0;
        en = 1'b1;
        duty = 8'd64;
        steps(300);

        high_count(8'd64);
        high_count(8'd0);
        high_count(8'd255);
        high_count(8'($urandom_range(1, 254)));

        steps(int'($urandom_range(20, 60)));
        en = 1'b0;
        #1 check_all();
        steps(10);
        en = 1'b1;
        steps(40);

        steps(37);
        #3 reset = 1'b1;
        model_reset();
        #1 check_all();
        steps(2);
        reset = 1'b0;
        steps(300);

        en = 1'b0;
        duty = 8'd64;
        steps(2);
        en = 1'b1;
        steps(100);
        duty = 8'd192;
        step();
`ifdef DOWNCOUNTER_PWM_SHADOW_EN
        check("duty_change_next", b4.pwm_out, 32'd0);
`else
        check("duty_change_next", b4.pwm_out, 32'd1);
`endif
        steps(500);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) duty = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #3 reset = 1'b1;
                model_reset();
                #1 check_all();
                step();
                reset = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
